sign_div: RTL and testbench
===========================

Name: sign_div

Overview:
- Sequential signed divider: the inverse datapath of the signed 4-bit sequential multiplier.
- Takes an 8-bit signed dividend, such as a multiplier product, and a 4-bit signed divisor.
- Returns an 8-bit signed quotient and a 4-bit signed remainder.
- Uses a restoring shift-subtract loop with a start/done handshake. Sits beside the multiplier in the arithmetic test setup, so product/b can be checked against a.

Parameters:
- DW, 8, dividend and quotient width (fixed; the bench relies on it)
- VW, 4, divisor and remainder width (fixed)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge when not busy
- dividend  input  8  signed dividend, captured on accepted start
- divisor  input  4  signed divisor, captured on accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results are updated
- quotient  output  8  signed quotient, truncated toward zero
- remainder  output  4  signed remainder, same sign as dividend (or 0)
- dz  output  1  divide-by-zero flag for the current result
- ovf  output  1  overflow flag (-128 / -1) for the current result

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (async, any time, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, dz=0, ovf=0.
  - Internal registers cleared; no partial result survives.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE with start=1 at edge E0:
  - Capture dividend and divisor; go to PREP; busy=1.
  - In DONE, done drops at the same edge, so back-to-back operation is allowed.
- IDLE/DONE with start=0: go to or stay in IDLE; done=0.
- PREP (1 cycle):
  - Record sign_q = dividend[7]^divisor[3] and sign_r = dividend[7].
  - Form unsigned magnitudes |dividend| (8b, -128 -> 128) and |divisor| (4b, -8 -> 8).
  - Clear the 5-bit partial remainder; iteration counter = 7.
- ITER (8 cycles, MSB first):
  - Shift {partial, dividend magnitude} left by one.
  - Trial-subtract |divisor| from the 5-bit partial.
  - Non-negative: keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - Counter decrements; leave to FIX after the count-0 iteration.
- FIX (1 cycle):
  - Negate quotient magnitude if sign_q; negate remainder magnitude if sign_r.
  - Register the results into quotient and remainder; set dz and ovf.
  - Go to DONE with done=1 and busy=0.
- Latency:
  - Results and done are valid after edge E0+10.
  - done is high for exactly one cycle unless a new start arrives.
  - busy is high from after E0 through the FIX cycle.
- Divide by zero (divisor=0):
  - Same 10-cycle latency; quotient=0, remainder=0, dz=1, ovf=0.
- Overflow (dividend=-128, divisor=-1):
  - quotient=8'h80 (-128), remainder=0, ovf=1, dz=0.
- Otherwise dz=0 and ovf=0.
- Result identity: quotient*divisor+remainder == dividend and |remainder| < |divisor|, matching signed Verilog / and %.
- start while busy (PREP/ITER/FIX): ignored; operands are not recaptured.
- Input changes while busy: no effect.
- Outputs hold their last result until the next FIX or a reset.

Test Plan:
- Reset low for 2 cycles, release, then start with 100 / 7 -> after exactly 10 edges: done=1, quotient=14, remainder=2; done=0 on the next edge with no start.
- Sign combinations: -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2; -8/-8 -> q=1, r=0; 7/-8 -> q=0, r=7.
- Corners: 5/0 -> dz=1, q=0, r=0; -128/-1 -> ovf=1, q=-128, r=0; -128/1 -> q=-128, r=0, no flags.
- Handshake:
  - start pulsed again at cycles 3 and 7 of a 60/5 op -> single result q=12, r=0 at cycle 10.
  - start held high in the DONE cycle -> second op accepted, its done arrives 10 edges later.
- Reset mid-operation: assert rst_n=0 at ITER cycle 4 -> all outputs 0 immediately (async); a new 9/2 after release -> q=4, r=1.
- Loopback with the multiplier: 10 random signed a, b with b!=0; feed product and b -> quotient==a, remainder==0; print "correct total: 10 / 10".

Source files
------------

// File: rtl/sign_div.sv
// ============================================================================
// sign_div : sequential signed divider, 8-bit dividend / 4-bit divisor,
//            restoring shift-subtract loop with start/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sign_div #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dz,
   output logic          ovf
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int CW = $clog2(DW);

   state_t        state;
   state_t        state_next;

   logic [DW-1:0] dvd_q;
   logic [VW-1:0] dvs_q;
   logic [DW-1:0] acc;
   logic [VW-1:0] mag_b;
   logic [VW:0]   partial;
   logic [CW-1:0] cnt;
   logic          sign_q;
   logic          sign_r;

   logic [VW:0]   shifted;
   logic          trial_ok;
   logic [VW:0]   trial;
   logic          accept;
   logic          busy_next;

   // accept a request only from the idle-like states
   assign accept = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_next  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_PREP;
               busy_next  = 1'b1;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_PREP: begin
            state_next = S_ITER;
            busy_next  = 1'b1;
         end
         S_ITER: begin
            busy_next = 1'b1;
            if (cnt == '0) begin
               state_next = S_FIX;
            end
         end
         S_FIX: begin
            state_next = S_DONE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // partial never exceeds |divisor|-1 <= 7, so the low VW bits carry it
   assign shifted  = {partial[VW-1:0], acc[DW-1]};
   assign trial_ok = (shifted >= {1'b0, mag_b});
   assign trial    = shifted - {1'b0, mag_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q     <= '0;
         dvs_q     <= '0;
         acc       <= '0;
         mag_b     <= '0;
         partial   <= '0;
         cnt       <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= (state == S_FIX);

         if (accept) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
         end

         case (state)
            S_PREP: begin
               sign_q  <= dvd_q[DW-1] ^ dvs_q[VW-1];
               sign_r  <= dvd_q[DW-1];
               acc     <= dvd_q[DW-1] ? DW'(~dvd_q + 1'b1) : dvd_q;
               mag_b   <= dvs_q[VW-1] ? VW'(~dvs_q + 1'b1) : dvs_q;
               partial <= '0;
               cnt     <= CW'(DW - 1);
            end
            S_ITER: begin
               partial <= trial_ok ? trial : shifted;
               acc     <= {acc[DW-2:0], trial_ok};
               cnt     <= cnt - 1'b1;
            end
            S_FIX: begin
               // zero divisor forces a clean zero result; -128/-1 falls out as 8'h80
               if (dvs_q == '0) begin
                  quotient  <= '0;
                  remainder <= '0;
               end else begin
                  quotient  <= sign_q ? DW'(~acc + 1'b1) : acc;
                  remainder <= sign_r ? VW'(~partial[VW-1:0] + 1'b1)
                                      : partial[VW-1:0];
               end
               dz  <= (dvs_q == '0);
               ovf <= (dvd_q == {1'b1, {(DW-1){1'b0}}}) && (dvs_q == '1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sign_div.sv
// ============================================================================
// tb_sign_div : directed self-checking bench for sign_div.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sign_div;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       dz;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   sign_div #(.DW(8), .VW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dz        (dz),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called mid-cycle (1 time unit after a rising edge); returns 1 unit after
   // the edge that delivers done.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edz, input logic eovf);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = 8'h5A;
      divisor  = 4'h3;
      chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
      chk({tag, ".done_e0"}, 32'(done), 32'd0);
      repeat (9) @(posedge clk);
      #1;
      chk({tag, ".done_e9"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".q"},    32'(quotient), 32'(eq));
      chk({tag, ".r"},    32'(remainder), 32'(er));
      chk({tag, ".dz"},   32'(dz), 32'(edz));
      chk({tag, ".ovf"},  32'(ovf), 32'(eovf));
   endtask

   initial begin : main
      int correct;
      logic signed [3:0] ra;
      logic signed [3:0] rb;
      logic signed [7:0] prod;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.q",    32'(quotient), 32'd0);
      chk("rst.r",    32'(remainder), 32'd0);
      chk("rst.flags", 32'({dz, ovf}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("p100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("done_drop", 32'(done), 32'd0);
      chk("hold_q", 32'(quotient), 32'd14);

      // back-to-back: each call starts during the DONE cycle of the previous
      do_op("n100_7",  8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0);
      do_op("p100_n7", 8'd100, 4'h9, 8'hF2, 4'd2, 1'b0, 1'b0);
      do_op("n100_n7", 8'h9C, 4'h9, 8'd14, 4'hE, 1'b0, 1'b0);
      do_op("n8_n8",   8'hF8, 4'h8, 8'd1,  4'd0, 1'b0, 1'b0);
      do_op("p7_n8",   8'd7,  4'h8, 8'd0,  4'd7, 1'b0, 1'b0);
      do_op("div0",    8'd5,  4'd0, 8'd0,  4'd0, 1'b1, 1'b0);
      do_op("ovf",     8'h80, 4'hF, 8'h80, 4'd0, 1'b0, 1'b1);
      do_op("n128_1",  8'h80, 4'd1, 8'h80, 4'd0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // restarts at cycles 3 and 7 must be ignored
      dividend = 8'd60;
      divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      dividend = 8'd99; divisor = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      dividend = 8'd77; divisor = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hs.busy", 32'(busy), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("hs.done_e9", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("hs.done", 32'(done), 32'd1);
      chk("hs.q", 32'(quotient), 32'd12);
      chk("hs.r", 32'(remainder), 32'd0);
      @(posedge clk); #1;
      chk("hs.single", 32'(done), 32'd0);

      // asynchronous reset in the middle of ITER
      dividend = 8'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("mid.busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid.busy", 32'(busy), 32'd0);
      chk("mid.q", 32'(quotient), 32'd0);
      chk("mid.r", 32'(remainder), 32'd0);
      chk("mid.done", 32'(done), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op("p9_2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 1'b0);

      // loopback against a 4x4 signed product
      correct = 0;
      for (int i = 0; i < 10; i++) begin
         ra = 4'($urandom_range(15, 0));
         rb = 4'($urandom_range(15, 1));
         prod = 8'(ra) * 8'(rb);
         do_op("loop", prod, rb, 8'(ra), 4'd0, 1'b0, 1'b0);
         if (quotient === 8'(ra) && remainder === 4'd0) correct++;
      end
      $display("correct total: %0d / 10", correct);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
